// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the pipelined RV32 shift unit:
//               operation encodings, shift-amount width and a 32-bit
//               bit-reversal helper used to run right shifts on the
//               left-shift datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    localparam int SHAMT_W = 5;

    // Mirror a 32-bit word so that bit i moves to bit 31-i.
    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_fine8_32.sv
`default_nettype none
// ============================================================================
// Module      : shift_fine8_32
// Description : Combinational 0-7 bit left shift of a 32-bit word, built from
//               four 8-bit one-hot shift slices. Each slice sees its own byte
//               plus the byte below it so bits carry across slice borders;
//               the lowest slice is fed zeros from below.
// Ports       : data   [31:0] in  - word to shift
//               onehot [7:0]  in  - one-hot shift distance (bit k = shift k)
//               result [31:0] out - shifted word, zero filled
// Revision    : 1.0 - initial release
// ============================================================================
module shift_fine8_32 (
    input  logic [31:0] data,
    input  logic [7:0]  onehot,
    output logic [31:0] result
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            logic [15:0] w_pair;
            logic [7:0]  w_byte;

            if (gi == 0) begin : g_low
                assign w_pair = {data[7:0], 8'h00};
            end else begin : g_upper
                assign w_pair = {data[8*gi+7 -: 8], data[8*gi-1 -: 8]};
            end

            // Shift by k selects the 8-bit window ending k bits below the top.
            always_comb begin
                w_byte = '0;
                for (int k = 0; k < 8; k++) begin
                    if (onehot[k]) begin
                        w_byte = w_byte | w_pair[15-k -: 8];
                    end
                end
            end

            assign result[8*gi+7 -: 8] = w_byte;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Two-stage pipelined RV32 shift unit (SLL/SRL/SRA) with
//               valid/ready on both sides. Right shifts are done by
//               reversing the operand, shifting left and reversing back.
//               Stage 1 applies the byte (coarse) shift; stage 2 applies the
//               0-7 bit (fine) shift, the reversal and the SRA sign fill and
//               registers the result into the output registers.
// Ports       : clk, rst_n (sync, active low), flush
//               in_valid/in_ready/in_op/in_data/in_shamt/in_tag  - request
//               out_valid/out_ready/out_data/out_tag/out_err     - result
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe
    import shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    // Pipeline state
    logic               r_s1_valid;
    logic [XLEN-1:0]    r_s1_data;
    logic [7:0]         r_s1_fine;
    logic [SHAMT_W-1:0] r_s1_shamt;
    logic [1:0]         r_s1_op;
    logic               r_s1_sign;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    logic [XLEN-1:0]    r_out_data;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_err;

    // Handshake / advance control
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = !flush && w_s1_adv;
    assign w_accept = in_valid && in_ready;

    // Stage 1 datapath
    logic            w_is_right;
    logic [XLEN-1:0] w_pre;
    logic [XLEN-1:0] w_coarse;

    assign w_is_right = (in_op == OP_SRL) || (in_op == OP_SRA);
    assign w_pre      = w_is_right ? bitrev32(in_data) : in_data;
    // Illegal ops carry the raw operand so stage 2 can return it untouched.
    assign w_coarse   = (in_op == OP_ILL) ? in_data
                                          : (w_pre << {in_shamt[4:3], 3'b000});

    // Stage 2 datapath
    logic [XLEN-1:0] w_fine;
    logic [XLEN-1:0] w_rev;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_result;

    shift_fine8_32 u_fine (
        .data   (r_s1_data),
        .onehot (r_s1_fine),
        .result (w_fine)
    );

    always_comb begin
        w_rev    = bitrev32(w_fine);
        w_mask   = ~({XLEN{1'b1}} >> r_s1_shamt);
        w_result = r_s1_data;
        case (r_s1_op)
            OP_SLL:  w_result = w_fine;
            OP_SRL:  w_result = w_rev;
            OP_SRA:  w_result = w_rev | (r_s1_sign ? w_mask : '0);
            default: w_result = r_s1_data;
        endcase
    end

    // Valid bits and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_err  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_result;
                    r_out_tag  <= r_s1_tag;
                    r_out_err  <= (r_s1_op == OP_ILL);
                end
            end
        end
    end

    // Stage 1 payload; only meaningful while r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (w_accept && rst_n) begin
            r_s1_data  <= w_coarse;
            r_s1_fine  <= 8'(1) << in_shamt[2:0];
            r_s1_shamt <= in_shamt;
            r_s1_op    <= in_op;
            r_s1_sign  <= in_data[XLEN-1];
            r_s1_tag   <= in_tag;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_pipe
// Description : Directed self-checking bench for shift_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_err;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    shift_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    // Drive one op with out_ready=1 and collect its result.
    // lat counts negedges after the accepting edge until out_valid (2 expected).
    task automatic run_op(input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [3:0] tg,
                          output logic [31:0] rd, output logic [3:0] rt,
                          output logic re, output int lat);
        int w;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg;
        out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = out_data; rt = out_tag; re = out_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_err !== 1'b0) begin
            nfail++;
            $display("FAIL reset_outputs: valid=%b data=%h tag=%h err=%b, want 0/0/0/0",
                     out_valid, out_data, out_tag, out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        ntests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [3:0]  tg;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    task automatic test_ops();
        vec_t v [13];
        logic [31:0] rd; logic [3:0] rt; logic re; int lat;
        v[0]  = '{2'b00, 32'h0000_0001,  5'd9, 4'h5, 32'h0000_0200, 1'b0};
        v[1]  = '{2'b11, 32'h8000_0000,  5'd4, 4'h1, 32'hF800_0000, 1'b0};
        v[2]  = '{2'b11, 32'h8000_0000, 5'd31, 4'h2, 32'hFFFF_FFFF, 1'b0};
        v[3]  = '{2'b01, 32'h8000_0000, 5'd31, 4'h3, 32'h0000_0001, 1'b0};
        v[4]  = '{2'b00, 32'hDEAD_BEEF,  5'd0, 4'h4, 32'hDEAD_BEEF, 1'b0};
        v[5]  = '{2'b01, 32'hDEAD_BEEF,  5'd0, 4'h6, 32'hDEAD_BEEF, 1'b0};
        v[6]  = '{2'b11, 32'hDEAD_BEEF,  5'd0, 4'h7, 32'hDEAD_BEEF, 1'b0};
        v[7]  = '{2'b10, 32'hDEAD_BEEF,  5'd5, 4'h8, 32'hDEAD_BEEF, 1'b1};
        v[8]  = '{2'b01, 32'hDEAD_BEEF, 5'd12, 4'h9, 32'h000D_EADB, 1'b0};
        v[9]  = '{2'b11, 32'hDEAD_BEEF, 5'd12, 4'hA, 32'hFFFD_EADB, 1'b0};
        v[10] = '{2'b00, 32'hDEAD_BEEF, 5'd20, 4'hB, 32'hEEF0_0000, 1'b0};
        v[11] = '{2'b11, 32'h7000_0000,  5'd8, 4'hC, 32'h0070_0000, 1'b0};
        v[12] = '{2'b00, 32'h8000_0001, 5'd31, 4'hD, 32'h8000_0000, 1'b0};
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].d, v[i].sh, v[i].tg, rd, rt, re, lat);
            ntests++;
            if (lat !== 2) begin
                nfail++;
                $display("FAIL op%0d_latency: got %0d, want 2", i, lat);
            end
            ntests++;
            if (rd !== v[i].exp || re !== v[i].err || rt !== v[i].tg) begin
                nfail++;
                $display("FAIL op%0d_result: data=%h err=%b tag=%h, want data=%h err=%b tag=%h",
                         i, rd, re, rt, v[i].exp, v[i].err, v[i].tg);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_bb [4];
        logic [31:0] held_d;
        logic [3:0]  held_t;
        int nin, nout, c;
        exp_bb[0] = 32'h0000_0001; exp_bb[1] = 32'h0000_0008;
        exp_bb[2] = 32'h0000_0040; exp_bb[3] = 32'h0000_0200;
        nin = 0; nout = 0; c = 0;
        held_d = '0; held_t = '0;
        while (nout < 4 && c < 40) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (nin < 4) begin
                in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1;
                in_shamt = 5'(3 * nin); in_tag = 4'(nin);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                ntests++;
                if (in_ready !== 1'b0 || nin !== 2 || out_valid !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b_full: in_ready=%b accepted=%0d out_valid=%b, want 0/2/1",
                             in_ready, nin, out_valid);
                end
                held_d = out_data; held_t = out_tag;
            end
            if (c == 3 || c == 4) begin
                ntests++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t || in_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL b2b_hold: valid=%b data=%h tag=%h ready=%b, want 1/%h/%h/0",
                             out_valid, out_data, out_tag, in_ready, held_d, held_t);
                end
            end
            if (in_valid && in_ready) nin++;
            if (out_valid && out_ready) begin
                ntests++;
                if (out_tag !== 4'(nout) || out_data !== exp_bb[nout] || out_err !== 1'b0) begin
                    nfail++;
                    $display("FAIL b2b_order: tag=%h data=%h err=%b, want tag=%h data=%h err=0",
                             out_tag, out_data, out_err, 4'(nout), exp_bb[nout]);
                end
                nout++;
            end
            c++;
        end
        ntests++;
        if (nout !== 4) begin
            nfail++;
            $display("FAIL b2b_count: got %0d results, want 4", nout);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        ntests++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_no_dup: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic [3:0] rt; logic re; int lat;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h3; in_shamt = 5'd1; in_tag = 4'h1;
        @(negedge clk);
        in_tag = 4'h2;
        @(negedge clk);
        in_tag = 4'h3; flush = 1'b1;
        #1;
        ntests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            nfail++;
            $display("FAIL flush_ready: in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        ntests++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL flush_clear: out_valid=%b, want 0", out_valid);
        end
        run_op(2'b01, 32'hF000_0000, 5'd4, 4'h9, rd, rt, re, lat);
        ntests++;
        if (lat !== 2 || rt !== 4'h9 || rd !== 32'h0F00_0000 || re !== 1'b0) begin
            nfail++;
            $display("FAIL flush_next: lat=%0d tag=%h data=%h err=%b, want 2/9/0f000000/0",
                     lat, rt, rd, re);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [3:0] rt; logic re; int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h5; in_shamt = 5'd2; in_tag = 4'h4;
        @(negedge clk);
        in_tag = 4'h5; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        ntests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid: valid=%b data=%h tag=%h ready=%b, want 0/0/0/1",
                     out_valid, out_data, out_tag, in_ready);
        end
        @(negedge clk);
        ntests++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_drain: out_valid=%b, want 0", out_valid);
        end
        run_op(2'b11, 32'hC000_0000, 5'd1, 4'hE, rd, rt, re, lat);
        ntests++;
        if (lat !== 2 || rt !== 4'hE || rd !== 32'hE000_0000 || re !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_next: lat=%0d tag=%h data=%h err=%b, want 2/e/e0000000/0",
                     lat, rt, rd, re);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
